// File: rtl/whitening_lfsr_param.sv
// Parametrised LFSR whitener/de-whitener with a valid/ready stream and one-beat output register.
// Supports multiplicative scramble, multiplicative descramble and additive (frame-synchronous) modes.
module whitening_lfsr_param #(
   parameter int unsigned         LFSR_LEN = 7,
   parameter logic [LFSR_LEN-1:0] TAPS     = 7'b1001000,
   parameter logic [LFSR_LEN-1:0] SEED     = '0,
   parameter int unsigned         DATA_W   = 1,
   parameter int unsigned         MODE     = 0
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              trigger,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_last,
   output logic              in_ready,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last,
   input  logic              out_ready
);

   logic [LFSR_LEN-1:0] state;
   logic [LFSR_LEN-1:0] chain;
   logic [DATA_W-1:0]   beat;
   logic                fb;
   logic                shift_in;
   logic                valid_q;
   logic                accept;

   if (TAPS == '0) begin : g_err_taps
      $error("whitening_lfsr_param: TAPS must select at least one state bit");
   end
   if (MODE > 2) begin : g_err_mode
      $error("whitening_lfsr_param: MODE must be 0, 1 or 2");
   end
   if (MODE == 2 && SEED == '0) begin : g_err_seed
      $error("whitening_lfsr_param: additive mode with zero SEED locks the LFSR");
   end
   if (LFSR_LEN < 2 || LFSR_LEN > 32) begin : g_err_len
      $error("whitening_lfsr_param: LFSR_LEN out of range 2..32");
   end
   if (DATA_W < 1 || DATA_W > 32) begin : g_err_dw
      $error("whitening_lfsr_param: DATA_W out of range 1..32");
   end

   assign in_ready  = trigger && (!valid_q || out_ready);
   assign accept    = in_valid && in_ready;
   // Gated so a beat left over from a dropped frame is never seen downstream.
   assign out_valid = valid_q && trigger;

   always_comb begin
      chain    = state;
      beat     = '0;
      fb       = 1'b0;
      shift_in = 1'b0;
      for (int unsigned i = 0; i < DATA_W; i++) begin
         fb      = ^(chain & TAPS);
         beat[i] = in_data[i] ^ fb;
         if (MODE == 1) begin
            shift_in = in_data[i];
         end else if (MODE == 2) begin
            shift_in = fb;
         end else begin
            shift_in = beat[i];
         end
         chain = {chain[LFSR_LEN-2:0], shift_in};
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state    <= SEED;
         valid_q  <= 1'b0;
         out_data <= '0;
         out_last <= 1'b0;
      end else if (!trigger) begin
         state   <= SEED;
         valid_q <= 1'b0;
      end else if (accept) begin
         state    <= chain;
         valid_q  <= 1'b1;
         out_data <= beat;
         out_last <= in_last;
      end else if (out_ready) begin
         valid_q <= 1'b0;
      end
   end

endmodule

// File: doc/whitening_lfsr_param.md
Name: whitening_lfsr_param

Overview:
Parametrised data whitener/de-whitener for the camera link datapath. It generalises the 7-bit serial scrambler to configurable LFSR length, taps, seed and bits-per-beat. It supports self-synchronising scramble, self-synchronising descramble, and additive (frame-synchronous) modes. The block sits between the packetiser and the backscatter modulator, with a valid/ready stream on both sides and a one-beat output register.

Parameters:
LFSR_LEN, 7, LFSR state width in bits (2..32).
TAPS, 7'b1001000, feedback mask of width LFSR_LEN; bit k set means state[k] enters the feedback XOR. The default selects bits 3 and 6.
SEED, 0, state value loaded at reset and whenever trigger is low.
DATA_W, 1, bits processed per beat (1..32).
MODE, 0, 0 = multiplicative scramble, 1 = multiplicative descramble, 2 = additive.

Ports:
clock  in  1  system clock; all logic on rising edge.
reset  in  1  synchronous, active-low reset.
trigger  in  1  frame enable; low holds block idle and reloads SEED.
in_valid  in  1  input beat valid.
in_data  in  DATA_W  input bits; bit 0 is first in time.
in_last  in  1  last beat of frame; passed through with data.
in_ready  out  1  block accepts a beat this cycle.
out_valid  out  1  output beat valid.
out_data  out  DATA_W  whitened bits; bit 0 is first in time.
out_last  out  1  registered copy of in_last.
out_ready  in  1  downstream accepts a beat.

Behaviour:
- Reset (reset low at a clock edge): state=SEED, out_valid=0, out_data=0, out_last=0. Reset has priority over everything else.
- Idle (trigger low, reset high): state reloads SEED every cycle, out_valid forced 0, in_ready=0. out_data and out_last hold their values.
- Handshake (trigger high):
  - in_ready = !out_valid || out_ready (combinational).
  - A beat is accepted when in_valid && in_ready.
  - Latency is 1 cycle: the accepted beat appears on out_data/out_last with out_valid=1 in the next cycle.
  - If out_valid && !out_ready, out_data, out_last and state are held, in_ready=0, and no input is consumed.
  - If out_valid && out_ready && no accept: out_valid goes to 0 next cycle.
  - Accept and drain in the same cycle: the new beat replaces the old one, out_valid stays 1. Full throughput is 1 beat/cycle.
- Per-beat computation: bits are processed serially in order i = 0..DATA_W-1, within one cycle, chained through an intermediate state. For each bit:
  - fb = XOR over k of (s[k] & TAPS[k]).
  - o[i] = d[i] ^ fb.
  - Next s = {s[LFSR_LEN-2:0], x}, where x = o[i] for MODE 0, d[i] for MODE 1, fb for MODE 2.
  - After the last bit, the final chained state is registered. State advances only on an accepted beat.
- Compatibility: with all parameters at default, the bitstream is identical to the legacy serial whitener (taps 3 and 6, zero seed, cleared when trigger low).
- Round trip: MODE 1 with the same LFSR_LEN/TAPS/SEED inverts MODE 0 exactly. MODE 1 also resynchronises after LFSR_LEN error-free bits from any start state.
- Frame boundary: in_last has no effect on state. Frames are delimited by trigger, and the host drops trigger for at least 1 cycle between frames.
- Trigger falling edge mid-frame: a pending output beat is discarded (out_valid=0 next cycle) and state reloads SEED. Trigger rising again starts a fresh frame from SEED.
- Elaboration checks (simulation-only $error):
  - TAPS == 0.
  - MODE > 2.
  - MODE == 2 with SEED == 0, which would lock the additive LFSR at zero.
  - LFSR_LEN or DATA_W outside its range.
- Width rules: all XORs are 1-bit. No arithmetic, no overflow.

Test Plan:
- Default parameters, trigger=1, serial input bits 1,0,0,0,0,0,0,0 -> out bits 1,0,0,0,1,0,0,1, each 1 cycle after its accept.
- DATA_W=8, MODE 0, in_data=8'h01 -> out_data=8'h91. Feeding 8'h91 into a MODE 1 instance -> 8'h01.
- DATA_W=8, MODE 2, SEED=7'h7F, in_data=8'h00 -> first 5 output bits 0,0,0,0,1, matching a bit-serial reference model over 1000 random beats.
- Backpressure: out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0, out_data stable, state unchanged. Releasing out_ready -> 1 beat/cycle, no loss or duplication versus the model.
- Trigger dropped for 1 cycle after 3 beats with an output pending -> out_valid=0. The next frame's first beat is processed from SEED (8'h01 -> 8'h91 again in MODE 0).
- Reset low for 1 cycle during streaming -> next cycle out_valid=0, out_data=0, out_last=0, state=SEED. No output for the beat in flight.
